dmem_write_buffer: RTL and testbench

//   Posted-write buffer and load path between the single-cycle core's data port and a

---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 57 +++++
 rtl/dmem_write_buffer.sv | 141 ++++++++++++++
 tb/tb_dmem_write_buffer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types for the core data-port write buffer: bus widths, FSM states and
// the layout of one buffered store.
package mem_bus_pkg;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int WORD_OFS = 2;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    RD_WAIT,
    RD_DONE
  } wb_state_t;

  typedef struct packed {
    logic [AW-1:WORD_OFS] waddr;
    logic [DW-1:0]        data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Store FIFO with a per-slot valid mask; every slot is visible so the load
// path can search the pending stores.
module wb_fifo
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IW = $clog2(DEPTH),
  localparam int PW = IW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [PW-1:0]         count,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]      valid,
  output logic [IW-1:0]         head_idx,
  output wb_entry_t             head
);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // One extra pointer bit tells a full ring from an empty one.
  assign full     = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign count    = wr_ptr - rd_ptr;
  assign head_idx = rd_ptr[IW-1:0];
  assign head     = entries[head_idx];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid   <= '0;
      entries <= '0;
    end else begin
      if (do_push) begin
        entries[wr_ptr[IW-1:0]] <= push_entry;
        valid[wr_ptr[IW-1:0]]   <= 1'b1;
        wr_ptr                  <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        valid[rd_ptr[IW-1:0]] <= 1'b0;
        rd_ptr                <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the core data port and a slow req/ready/rvalid
// memory: stores retire at once, loads forward from the buffer or stall on a miss.
module dmem_write_buffer
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic          memread,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] writedata,
  output logic [DW-1:0] readdata,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output wb_state_t     dbg_state
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  // Memory side is valid/ready: a request is taken on a cycle with
  // mem_req && mem_ready, and mem_we/mem_addr/mem_wdata stay put until then.

  wb_state_t             state, state_nx;
  logic                  full, empty, pop;
  logic [PW-1:0]         fifo_count;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic [IW-1:0]         head_idx;
  wb_entry_t             head;
  wb_entry_t             push_entry;
  logic                  is_load, load_miss, load_stall;
  logic                  fwd_hit;
  logic [DW-1:0]         fwd_data;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         rdata_q;
  logic                  unused_bits;

  assign push_entry  = '{waddr: addr[AW-1:WORD_OFS], data: writedata};
  assign is_load     = memread && !memwrite;
  assign load_miss   = is_load && !fwd_hit;
  assign dbg_state   = state;
  assign unused_bits = ^{addr[WORD_OFS-1:0], fifo_count};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (memwrite),
    .push_entry(push_entry),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count),
    .entries   (entries),
    .valid     (valid),
    .head_idx  (head_idx),
    .head      (head)
  );

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_idx + IW'(i);
      if (valid[idx] && (entries[idx].waddr == addr[AW-1:WORD_OFS])) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    load_stall = 1'b0;
    case (state)
      IDLE: begin
        if (load_miss) begin
          load_stall = 1'b1;
          state_nx   = RD_REQ;
        end else if (!empty) begin
          state_nx = WR_REQ;
        end
      end
      WR_REQ: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = {head.waddr, {WORD_OFS{1'b0}}};
        mem_wdata  = head.data;
        load_stall = load_miss;
        if (mem_ready) begin
          pop      = 1'b1;
          state_nx = IDLE;
        end
      end
      RD_REQ: begin
        mem_req    = 1'b1;
        mem_addr   = {addr[AW-1:WORD_OFS], {WORD_OFS{1'b0}}};
        load_stall = 1'b1;
        if (mem_ready) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        load_stall = 1'b1;
        if (mem_rvalid) state_nx = RD_DONE;
      end
      RD_DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A full buffer holds the store even if a pop lands this cycle.
  assign stall    = load_stall || (memwrite && full);
  assign readdata = (is_load && fwd_hit && (state != RD_DONE)) ? fwd_data : rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if ((state == RD_WAIT) && mem_rvalid) rdata_q <= mem_rdata;
    end
  end

  a_no_load_store: assert property (@(posedge clk) disable iff (!reset) !(memwrite && memread));

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed checks of the dmem write buffer: reset, forwarding, miss timing,
// full-buffer stall and write/read ordering.
module tb_dmem_write_buffer;
  import mem_bus_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          memwrite = 1'b0, memread = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] writedata = '0;
  logic [DW-1:0] readdata;
  logic          stall, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  wb_state_t     dbg_state;

  int total = 0;
  int bad = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] act_q[$];

  always #5 clk = ~clk;

  dmem_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
    .addr(addr), .writedata(writedata), .readdata(readdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // Inputs change just after posedge, so negedge sees the accepted write.
  always @(negedge clk)
    if (reset && mem_req && mem_we && mem_ready) act_q.push_back({mem_addr, mem_wdata});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    memwrite = 1'b0; memread = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic drain(input int cycles);
    drive_idle();
    mem_ready = 1'b1;
    repeat (cycles) tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    tick(); tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall); end
    total++; if ({mem_req, mem_we} !== 2'b00) begin bad++; $display("FAIL rst_req: got %b want 00", {mem_req, mem_we}); end
    total++; if ({mem_addr, mem_wdata} !== '0) begin bad++; $display("FAIL rst_bus: got %h want 0", {mem_addr, mem_wdata}); end
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", readdata); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_write();
    act_q.delete();
    memwrite = 1'b1; addr = 32'h300; writedata = 32'hAA;
    tick();
    memwrite = 1'b0;
    tick();
    total++; if ({mem_req, mem_we, mem_addr} !== {2'b11, 32'h300}) begin
      bad++; $display("FAIL mid_wr_req: got %b%b %h want 11 300", mem_req, mem_we, mem_addr); end
    #2 reset = 1'b0;
    #1;
    total++; if ({mem_req, stall} !== 2'b00) begin bad++; $display("FAIL mid_rst_req: got %b want 00", {mem_req, stall}); end
    total++; if ({readdata, mem_addr} !== '0) begin bad++; $display("FAIL mid_rst_bus: got %h want 0", {readdata, mem_addr}); end
    tick();
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (3) begin
      tick();
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mid_rst_empty: got req %b want 0", mem_req); end
    end
    mem_ready = 1'b0;
    total++; if (act_q.size() != 0) begin bad++; $display("FAIL mid_rst_writes: got %0d want 0", act_q.size()); end
  endtask

  task automatic test_forward();
    act_q.delete(); exp_q.delete();
    exp_q.push_back({32'h100, 32'hDEADBEEF});
    memwrite = 1'b1; addr = 32'h100; writedata = 32'hDEADBEEF;
    tick();
    memwrite = 1'b0; memread = 1'b1;
    #1;
    total++; if (readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL fwd_data: got %h want deadbeef", readdata); end
    total++; if ({stall, mem_req} !== 2'b00) begin bad++; $display("FAIL fwd_stall: got %b want 00", {stall, mem_req}); end
    tick();
    memread = 1'b0;
    #1;
    total++; if ({mem_req, mem_we} !== 2'b11) begin bad++; $display("FAIL fwd_noread: got %b want 11", {mem_req, mem_we}); end
    drain(4);
    total++; if (act_q != exp_q) begin bad++; $display("FAIL fwd_drain: got %0d writes want %0d", act_q.size(), exp_q.size()); end
  endtask

  task automatic test_forward_youngest();
    act_q.delete(); exp_q.delete();
    exp_q.push_back({32'h40, 32'd1});
    exp_q.push_back({32'h40, 32'd2});
    memwrite = 1'b1; addr = 32'h40; writedata = 32'd1;
    tick();
    addr = 32'h43; writedata = 32'd2;
    tick();
    memwrite = 1'b0; memread = 1'b1; addr = 32'h40;
    #1;
    total++; if ({stall, readdata} !== {1'b0, 32'd2}) begin bad++; $display("FAIL young_40: got %b %h want 0 2", stall, readdata); end
    addr = 32'h42;
    #1;
    total++; if (readdata !== 32'd2) begin bad++; $display("FAIL young_42: got %h want 2", readdata); end
    addr = 32'h44;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL young_miss: got stall %b want 1", stall); end
    drain(8);
    total++; if (act_q != exp_q) begin bad++; $display("FAIL young_drain: got %0d writes want %0d", act_q.size(), exp_q.size()); end
  endtask

  task automatic test_load_miss();
    int stalls = 0;
    memread = 1'b1; addr = 32'h200; mem_ready = 1'b1; mem_rdata = 32'h12345678;
    for (int k = 0; k < 6; k++) begin
      mem_rvalid = (k == 4);
      #1;
      if (stall) stalls++;
      if (k == 1) begin
        total++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h200}) begin
          bad++; $display("FAIL miss_req: got %b%b %h want 10 200", mem_req, mem_we, mem_addr); end
      end
      if (k == 5) begin
        total++; if ({dbg_state, stall} !== {RD_DONE, 1'b0}) begin
          bad++; $display("FAIL miss_done: got state %0d stall %b want RD_DONE 0", dbg_state, stall); end
        total++; if (readdata !== 32'h12345678) begin bad++; $display("FAIL miss_data: got %h want 12345678", readdata); end
      end
      tick();
    end
    total++; if (stalls != 5) begin bad++; $display("FAIL miss_stalls: got %0d want 5", stalls); end
    drive_idle();
    #1;
    total++; if ({dbg_state, readdata} !== {IDLE, 32'h12345678}) begin
      bad++; $display("FAIL miss_hold: got %0d %h want IDLE 12345678", dbg_state, readdata); end
  endtask

  task automatic test_back_to_back();
    act_q.delete(); exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back({32'h500 + 32'(4 * i), 32'hA0 + 32'(i)});
    memwrite = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'h500 + 32'(4 * i); writedata = 32'hA0 + 32'(i);
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_push%0d: got stall %b want 0", i, stall); end
      tick();
    end
    addr = 32'h510; writedata = 32'hA4;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_full: got stall %b want 1", stall); end
    tick();
    mem_ready = 1'b1;
    #1;
    total++; if ({stall, mem_addr} !== {1'b1, 32'h500}) begin
      bad++; $display("FAIL b2b_pop: got %b %h want 1 500", stall, mem_addr); end
    tick();
    mem_ready = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_release: got stall %b want 0", stall); end
    tick();
    drain(12);
    total++; if (act_q.size() != exp_q.size()) begin
      bad++; $display("FAIL b2b_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      total++; if (act_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_order%0d: got %h want %h", i, act_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_miss_during_write();
    act_q.delete(); exp_q.delete();
    exp_q.push_back({32'h600, 32'h66});
    memwrite = 1'b1; addr = 32'h600; writedata = 32'h66;
    tick();
    memwrite = 1'b0;
    tick();
    memread = 1'b1; addr = 32'h700;
    for (int k = 0; k < 3; k++) begin
      mem_ready = (k == 2);
      #1;
      total++; if ({stall, mem_req, mem_we, mem_addr, mem_wdata} !== {3'b111, 32'h600, 32'h66}) begin
        bad++; $display("FAIL mdw_hold%0d: got %b%b%b %h %h want 111 600 66", k, stall, mem_req, mem_we, mem_addr, mem_wdata); end
      tick();
    end
    #1;
    total++; if ({dbg_state, stall, mem_req} !== {IDLE, 2'b10}) begin
      bad++; $display("FAIL mdw_idle: got %0d %b%b want IDLE 10", dbg_state, stall, mem_req); end
    tick();
    total++; if ({stall, mem_req, mem_we, mem_addr} !== {3'b110, 32'h700}) begin
      bad++; $display("FAIL mdw_rdreq: got %b%b%b %h want 110 700", stall, mem_req, mem_we, mem_addr); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mdw_wait: got stall %b want 1", stall); end
    tick();
    mem_rvalid = 1'b0;
    #1;
    total++; if ({stall, readdata} !== {1'b0, 32'h77}) begin bad++; $display("FAIL mdw_done: got %b %h want 0 77", stall, readdata); end
    tick();
    drive_idle();
    total++; if (act_q != exp_q) begin bad++; $display("FAIL mdw_writes: got %0d want %0d", act_q.size(), exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_forward();
    test_forward_youngest();
    test_load_miss();
    test_back_to_back();
    test_miss_during_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish by 100000");
    $fatal(1);
  end

endmodule
